// File: rtl/fixed_point_issue_controller_pkg.sv
// Shared opcodes, park opcode and controller state encodings for the
// fixed-point issue controller.
package fixed_point_issue_controller_pkg;

    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    // Opcode held on the unit between commands so the MUL/SQRT sequencers reset.
    localparam logic [1:0] PARK_OP  = FPU_ADD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic is_multi_cycle(input logic [1:0] op);
        return (op == FPU_MUL) || (op == FPU_SQRT);
    endfunction

endpackage

// File: rtl/fixed_point_issue_controller.sv
// Issue/hold/write-back sequencer in front of the fixed-point unit; parks the
// unit opcode between commands and times out unresponsive multi-cycle ops.
module fixed_point_issue_controller
    import fixed_point_issue_controller_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 64,
    parameter int MIN_WAIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [1:0]       req_operation,
    input  logic [4:0]       req_rd,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_result,
    output logic [4:0]       wb_rd,
    output logic             wb_error,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    logic [CW-1:0]    r_wait_cnt;
    logic [4:0]       r_rd;
    logic             r_req_ready;
    logic             r_busy;
    logic [WIDTH-1:0] r_fpu_operand_1;
    logic [WIDTH-1:0] r_fpu_operand_2;
    logic [1:0]       r_fpu_operation;
    logic             r_wb_valid;
    logic [WIDTH-1:0] r_wb_result;
    logic [4:0]       r_wb_rd;
    logic             r_wb_error;

    // Command FSM; the fpu_* registers double as the latched command while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_wait_cnt      <= '0;
            r_rd            <= 5'd0;
            r_req_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_fpu_operand_1 <= '0;
            r_fpu_operand_2 <= '0;
            r_fpu_operation <= PARK_OP;
            r_wb_valid      <= 1'b0;
            r_wb_result     <= '0;
            r_wb_rd         <= 5'd0;
            r_wb_error      <= 1'b0;
        end else if (flush) begin
            r_state         <= ST_IDLE;
            r_wait_cnt      <= '0;
            r_req_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_fpu_operand_1 <= '0;
            r_fpu_operand_2 <= '0;
            r_fpu_operation <= PARK_OP;
            r_wb_valid      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_fpu_operand_1 <= req_operand_1;
                        r_fpu_operand_2 <= req_operand_2;
                        r_fpu_operation <= req_operation;
                        r_rd            <= req_rd;
                        r_req_ready     <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    if (is_multi_cycle(r_fpu_operation)) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_wb_result     <= fpu_result;
                        r_wb_error      <= 1'b0;
                        r_wb_rd         <= r_rd;
                        r_wb_valid      <= 1'b1;
                        r_fpu_operand_1 <= '0;
                        r_fpu_operand_2 <= '0;
                        r_fpu_operation <= PARK_OP;
                        r_state         <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt != {CW{1'b1}}) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                    // A qualified ready wins over a timeout landing in the same cycle.
                    if (fpu_ready && (r_wait_cnt >= CW'(MIN_WAIT))) begin
                        r_wb_result     <= fpu_result;
                        r_wb_error      <= 1'b0;
                        r_wb_rd         <= r_rd;
                        r_wb_valid      <= 1'b1;
                        r_fpu_operand_1 <= '0;
                        r_fpu_operand_2 <= '0;
                        r_fpu_operation <= PARK_OP;
                        r_state         <= ST_RESP;
                    end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        r_wb_result     <= '0;
                        r_wb_error      <= 1'b1;
                        r_wb_rd         <= r_rd;
                        r_wb_valid      <= 1'b1;
                        r_fpu_operand_1 <= '0;
                        r_fpu_operand_2 <= '0;
                        r_fpu_operation <= PARK_OP;
                        r_state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (wb_ready) begin
                        r_wb_valid  <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_req_ready     <= 1'b1;
                    r_busy          <= 1'b0;
                    r_wb_valid      <= 1'b0;
                    r_fpu_operation <= PARK_OP;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign busy          = r_busy;
    assign fpu_operand_1 = r_fpu_operand_1;
    assign fpu_operand_2 = r_fpu_operand_2;
    assign fpu_operation = r_fpu_operation;
    assign wb_valid      = r_wb_valid;
    assign wb_result     = r_wb_result;
    assign wb_rd         = r_wb_rd;
    assign wb_error      = r_wb_error;

endmodule
